// File: rtl/qed_reg_file_chk_if.sv
// Bus bundle for the SQED register file: write/commit inputs, read ports and
// consistency-checker status.
interface qed_reg_file_chk_if #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int NRD   = 2,
  parameter int CNT_W = 16
);
  localparam int AW = $clog2(NREG);

  logic                wr_en;
  logic [AW-1:0]       wr_idx;
  logic [XLEN-1:0]     wr_data;
  logic                qed_vld;
  logic [NRD*AW-1:0]   rd_idx;
  logic [NRD*XLEN-1:0] rd_data;
  logic [CNT_W-1:0]    orig_cnt;
  logic [CNT_W-1:0]    dup_cnt;
  logic                qed_ready;
  logic                chk_busy;
  logic                chk_done;
  logic                chk_fail;
  logic [AW-1:0]       chk_fail_idx;
  logic                chk_abort;

  modport master (
    output wr_en, wr_idx, wr_data, qed_vld, rd_idx,
    input  rd_data, orig_cnt, dup_cnt, qed_ready,
           chk_busy, chk_done, chk_fail, chk_fail_idx, chk_abort
  );

  modport slave (
    input  wr_en, wr_idx, wr_data, qed_vld, rd_idx,
    output rd_data, orig_cnt, dup_cnt, qed_ready,
           chk_busy, chk_done, chk_fail, chk_fail_idx, chk_abort
  );
endinterface

// File: rtl/qed_reg_file_chk.sv
// Multi-read-port register file whose lower half holds original registers and
// upper half their SQED duplicates, with commit counters and a pairwise scan checker.
module qed_reg_file_chk #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int BYPASS = 1,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  qed_reg_file_chk_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int H  = NREG / 2;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t              r_state;
  logic [XLEN-1:0]     r_mem [NREG];
  logic [NRD*XLEN-1:0] r_rd_data;
  logic [CNT_W-1:0]    r_orig_cnt;
  logic [CNT_W-1:0]    r_dup_cnt;
  logic [AW-1:0]       r_ptr;
  logic [AW-1:0]       r_fail_idx;
  logic                r_fail;
  logic                r_done;
  logic                r_abort;

  logic                w_wr_act;
  logic                w_commit;
  logic                w_upper;
  logic                w_scan_rdy;
  logic                w_mismatch;
  logic [CNT_W-1:0]    w_orig_nxt;
  logic [CNT_W-1:0]    w_dup_nxt;
  logic [AW-1:0]       w_dup_ptr;
  logic [NRD*XLEN-1:0] w_rd_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Index 0 is the hardwired zero register, so it never writes or commits.
  assign w_wr_act = bus.wr_en && (bus.wr_idx != '0);
  assign w_commit = w_wr_act && bus.qed_vld;
  assign w_upper  = bus.wr_idx[AW-1];

  assign w_orig_nxt = (w_commit && !w_upper) ? sat_inc(r_orig_cnt) : r_orig_cnt;
  assign w_dup_nxt  = (w_commit &&  w_upper) ? sat_inc(r_dup_cnt)  : r_dup_cnt;
  assign w_scan_rdy = (w_orig_nxt == w_dup_nxt) && (w_orig_nxt != '0);

  // Pointer stays in the lower half, so its duplicate just sets the top bit.
  assign w_dup_ptr  = {1'b1, r_ptr[AW-2:0]};
  assign w_mismatch = (r_mem[r_ptr] != r_mem[w_dup_ptr]);

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] w_idx;
    logic          w_byp;
    assign w_idx = bus.rd_idx[k*AW +: AW];
    assign w_byp = (BYPASS != 0) && w_wr_act && (bus.wr_idx == w_idx);
    assign w_rd_nxt[k*XLEN +: XLEN] = (w_idx == '0) ? '0 :
                                      w_byp         ? bus.wr_data :
                                                      r_mem[w_idx];
  end

  // Storage, read-port registers and commit counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < NREG; j++) r_mem[j] <= '0;
      r_rd_data  <= '0;
      r_orig_cnt <= '0;
      r_dup_cnt  <= '0;
    end else begin
      if (w_wr_act) r_mem[bus.wr_idx] <= bus.wr_data;
      r_rd_data  <= w_rd_nxt;
      r_orig_cnt <= w_orig_nxt;
      r_dup_cnt  <= w_dup_nxt;
    end
  end

  // Scan FSM: any nonzero write during a scan invalidates the comparison.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_fail     <= 1'b0;
      r_fail_idx <= '0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_commit && w_scan_rdy) begin
            r_state    <= S_SCAN;
            r_ptr      <= AW'(1);
            r_fail     <= 1'b0;
            r_fail_idx <= '0;
          end
        end
        S_SCAN: begin
          if (w_wr_act) begin
            r_state <= S_IDLE;
            r_abort <= 1'b1;
          end else if (w_mismatch) begin
            r_state    <= S_DONE;
            r_fail     <= 1'b1;
            r_fail_idx <= r_ptr;
            r_done     <= 1'b1;
          end else if (r_ptr == AW'(H - 1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_ptr <= r_ptr + AW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_data      = r_rd_data;
  assign bus.orig_cnt     = r_orig_cnt;
  assign bus.dup_cnt      = r_dup_cnt;
  assign bus.qed_ready    = (r_orig_cnt == r_dup_cnt) && (r_orig_cnt != '0);
  assign bus.chk_busy     = (r_state == S_SCAN);
  assign bus.chk_done     = r_done;
  assign bus.chk_fail     = r_fail;
  assign bus.chk_fail_idx = r_fail_idx;
  assign bus.chk_abort    = r_abort;
endmodule

// File: tb/tb_qed_reg_file_chk.sv
// Directed bench for qed_reg_file_chk: a BYPASS=1 and a BYPASS=0 instance share stimulus.
module tb_qed_reg_file_chk;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_idx = '0;
  logic [31:0] wr_data = '0;
  logic        qed_vld = 1'b0;
  logic [4:0]  rd0 = '0;
  logic [4:0]  rd1 = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  qed_reg_file_chk_if #(.XLEN(32), .NREG(32), .NRD(2), .CNT_W(4)) ifa ();
  qed_reg_file_chk_if #(.XLEN(32), .NREG(32), .NRD(2), .CNT_W(4)) ifb ();

  assign ifa.wr_en = wr_en;  assign ifb.wr_en = wr_en;
  assign ifa.wr_idx = wr_idx; assign ifb.wr_idx = wr_idx;
  assign ifa.wr_data = wr_data; assign ifb.wr_data = wr_data;
  assign ifa.qed_vld = qed_vld; assign ifb.qed_vld = qed_vld;
  assign ifa.rd_idx = {rd1, rd0}; assign ifb.rd_idx = {rd1, rd0};

  qed_reg_file_chk #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  qed_reg_file_chk #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(0), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct {
    logic        we;
    logic [4:0]  widx;
    logic [31:0] wdata;
    logic        qv;
    logic [4:0]  r0, r1;
    logic [31:0] ea0, ea1, eb0, eb1;
    logic [3:0]  eo, ed;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] idx, input logic [31:0] d, input logic qv);
    wr_en = we; wr_idx = idx; wr_data = d; qed_vld = qv;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic start_scan();
    drive(1'b1, 5'd1, 32'd7, 1'b1);
    step();
    drive(1'b1, 5'd17, 32'd7, 1'b1);
    step();
    idle();
  endtask

  int n;

  initial begin
    tbl[0] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd5,
               32'h0,         32'h0,         32'h0,         32'h0,         4'd0, 4'd0};
    tbl[1] = '{1'b1, 5'd3,  32'hDEAD_BEEF, 1'b0, 5'd3,  5'd0,
               32'hDEAD_BEEF, 32'h0,         32'h0,         32'h0,         4'd0, 4'd0};
    tbl[2] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd3,  5'd3,
               32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'd0, 4'd0};
    tbl[3] = '{1'b1, 5'd0,  32'h1234,      1'b1, 5'd0,  5'd3,
               32'h0,         32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF, 4'd0, 4'd0};
    tbl[4] = '{1'b1, 5'd16, 32'h55,        1'b0, 5'd16, 5'd16,
               32'h55,        32'h55,        32'h0,         32'h0,         4'd0, 4'd0};
    tbl[5] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd16, 5'd0,
               32'h55,        32'h0,         32'h55,        32'h0,         4'd0, 4'd0};

    do_reset();
    chk("rst_rd", {32'h0, ifa.rd_data}, 64'h0);
    chk("rst_cnt", {ifa.orig_cnt, ifa.dup_cnt}, 64'h0);
    chk("rst_chk", {ifa.qed_ready, ifa.chk_busy, ifa.chk_done, ifa.chk_fail,
                    ifa.chk_fail_idx, ifa.chk_abort}, 64'h0);

    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].we, tbl[i].widx, tbl[i].wdata, tbl[i].qv);
      rd0 = tbl[i].r0;
      rd1 = tbl[i].r1;
      step();
      chk($sformatf("vec%0d_a_rd0", i), ifa.rd_data[31:0],  tbl[i].ea0);
      chk($sformatf("vec%0d_a_rd1", i), ifa.rd_data[63:32], tbl[i].ea1);
      chk($sformatf("vec%0d_b_rd0", i), ifb.rd_data[31:0],  tbl[i].eb0);
      chk($sformatf("vec%0d_b_rd1", i), ifb.rd_data[63:32], tbl[i].eb1);
      chk($sformatf("vec%0d_orig", i), ifa.orig_cnt, tbl[i].eo);
      chk($sformatf("vec%0d_dup", i),  ifa.dup_cnt,  tbl[i].ed);
      chk($sformatf("vec%0d_busy", i), ifa.chk_busy, 1'b0);
    end
    idle();

    // Full passing scan
    do_reset();
    drive(1'b1, 5'd1, 32'd7, 1'b1);
    step();
    chk("pass_orig1", {ifa.orig_cnt, ifa.dup_cnt, ifa.qed_ready, ifa.chk_busy}, {4'd1, 4'd0, 1'b0, 1'b0});
    drive(1'b1, 5'd17, 32'd7, 1'b1);
    step();
    idle();
    chk("pass_ready", {ifa.orig_cnt, ifa.dup_cnt, ifa.qed_ready, ifa.chk_busy}, {4'd1, 4'd1, 1'b1, 1'b1});
    n = 0;
    while (ifa.chk_busy && n < 40) begin
      n++;
      step();
    end
    chk("pass_len", n, 15);
    chk("pass_done", {ifa.chk_done, ifa.chk_fail}, {1'b1, 1'b0});
    step();
    chk("pass_done_pulse", {ifa.chk_done, ifa.chk_busy}, 2'b00);

    // Mismatch at pair 2
    do_reset();
    drive(1'b1, 5'd2, 32'd4, 1'b0);
    step();
    drive(1'b1, 5'd18, 32'd5, 1'b0);
    step();
    start_scan();
    n = 0;
    while (ifa.chk_busy && n < 40) begin
      n++;
      step();
    end
    chk("fail_len", n, 2);
    chk("fail_res", {ifa.chk_done, ifa.chk_fail, ifa.chk_fail_idx}, {1'b1, 1'b1, 5'd2});
    step();
    chk("fail_hold", {ifa.chk_done, ifa.chk_fail, ifa.chk_fail_idx}, {1'b0, 1'b1, 5'd2});

    // Abort in the third scan cycle
    do_reset();
    start_scan();
    chk("abort_busy1", ifa.chk_busy, 1'b1);
    step();
    step();
    chk("abort_busy3", ifa.chk_busy, 1'b1);
    drive(1'b1, 5'd9, 32'h99, 1'b0);
    step();
    idle();
    chk("abort_pulse", {ifa.chk_abort, ifa.chk_busy, ifa.chk_done}, 3'b100);
    chk("abort_cnt", {ifa.orig_cnt, ifa.dup_cnt}, {4'd1, 4'd1});
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (ifa.chk_done || ifa.chk_busy || ifa.chk_abort) n++;
    end
    chk("abort_quiet", n, 0);

    // Reset in the middle of a scan
    do_reset();
    rd0 = 5'd1;
    rd1 = 5'd17;
    start_scan();
    step();
    chk("mid_busy", ifa.chk_busy, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_rd", {32'h0, ifa.rd_data}, 64'h0);
    chk("mid_rst_st", {ifa.orig_cnt, ifa.dup_cnt, ifa.qed_ready, ifa.chk_busy,
                       ifa.chk_done, ifa.chk_fail, ifa.chk_abort}, 64'h0);
    step();
    chk("mid_after", {ifa.chk_busy, ifa.chk_done, ifa.chk_abort}, 3'b000);
    chk("mid_rd_zero", ifa.rd_data[31:0], 32'h0);

    // Counter saturation at 4 bits
    do_reset();
    rd0 = 5'd0;
    rd1 = 5'd0;
    for (int c = 0; c < 14; c++) begin
      drive(1'b1, 5'd1, c, 1'b1);
      step();
    end
    chk("sat_14", ifa.orig_cnt, 4'd14);
    drive(1'b1, 5'd1, 32'd0, 1'b1);
    step();
    chk("sat_15", ifa.orig_cnt, 4'd15);
    step();
    step();
    idle();
    chk("sat_hold", {ifa.orig_cnt, ifa.dup_cnt}, {4'd15, 4'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
